// File: rtl/cmp_sort4_ctrl.sv
// Sorts four unsigned W-bit words ascending with a single shared comparator,
// one compare per clock (bubble sort with early exit), start/done handshake.
module cmp_sort4_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [4*W-1:0] i_din,
  output logic           o_busy,
  output logic           o_done,
  output logic [4*W-1:0] o_dout,
  output logic [2:0]     o_swaps,
  output logic           o_eq_seen
);

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [3:0][W-1:0]  r_w, w_sw;
  logic [3:0][W-1:0]  r_dout;
  logic [1:0]         r_pass, r_idx;
  logic               r_pass_swap, r_eq, r_eq_seen;
  logic [2:0]         r_cnt, r_swaps;

  logic [1:0]         w_idx_b, w_last;
  logic [W-1:0]       w_a, w_b;
  logic               w_gt, w_eq, w_pass_end, w_finish;

  // Shared comparator and the work array after this cycle's optional swap.
  always_comb begin
    w_idx_b    = r_idx + 2'd1;
    w_last     = 2'd2 - r_pass;
    w_a        = r_w[r_idx];
    w_b        = r_w[w_idx_b];
    w_gt       = w_a > w_b;
    w_eq       = w_a == w_b;
    w_pass_end = r_idx == w_last;
    w_finish   = w_pass_end && ((r_pass == 2'd2) || !(r_pass_swap || w_gt));
    w_sw       = r_w;
    if (w_gt) begin
      w_sw[r_idx]   = w_b;
      w_sw[w_idx_b] = w_a;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_next = StCmp;
      StCmp:   if (w_finish) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_w         <= '0;
      r_dout      <= '0;
      r_pass      <= '0;
      r_idx       <= '0;
      r_pass_swap <= 1'b0;
      r_eq        <= 1'b0;
      r_eq_seen   <= 1'b0;
      r_cnt       <= '0;
      r_swaps     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_w         <= i_din;
            r_pass      <= '0;
            r_idx       <= '0;
            r_pass_swap <= 1'b0;
            r_cnt       <= '0;
            r_eq        <= 1'b0;
          end
        end
        StCmp: begin
          r_w <= w_sw;
          if (w_gt) begin
            r_cnt       <= r_cnt + 3'd1;
            r_pass_swap <= 1'b1;
          end
          if (w_eq) r_eq <= 1'b1;
          if (!w_pass_end) begin
            r_idx <= w_idx_b;
          end else if (w_finish) begin
            // Results land on the edge into DONE so they appear alongside done.
            r_dout    <= w_sw;
            r_swaps   <= r_cnt + {2'b00, w_gt};
            r_eq_seen <= r_eq | w_eq;
          end else begin
            r_pass      <= r_pass + 2'd1;
            r_idx       <= '0;
            r_pass_swap <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy    = r_state != StIdle;
  assign o_done    = r_state == StDone;
  assign o_dout    = r_dout;
  assign o_swaps   = r_swaps;
  assign o_eq_seen = r_eq_seen;

endmodule

// File: tb/tb_cmp_sort4_ctrl.sv
// Self-checking bench for cmp_sort4_ctrl: directed and random sorts against a
// bubble-sort reference model, back-to-back start spam and mid-sort reset.
module tb_cmp_sort4_ctrl;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [4*W-1:0] din, dout;
  logic           busy, done, eq_seen;
  logic [2:0]     swaps;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_sort4_ctrl #(.W(W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_din     (din),
    .o_busy    (busy),
    .o_done    (done),
    .o_dout    (dout),
    .o_swaps   (swaps),
    .o_eq_seen (eq_seen)
  );

  // Reference: plain bubble sort with early exit on a swap-free pass.
  function automatic void model(input logic [4*W-1:0] d, output logic [4*W-1:0] sorted,
                                output int nsw, output bit eq, output int ncmp);
    logic [W-1:0] v[4];
    logic [W-1:0] t;
    bit sw;
    for (int k = 0; k < 4; k++) v[k] = d[k*W +: W];
    nsw = 0; eq = 0; ncmp = 0;
    for (int p = 0; p < 3; p++) begin
      sw = 0;
      for (int i = 0; i < 3 - p; i++) begin
        ncmp++;
        if (v[i] > v[i+1]) begin
          t = v[i]; v[i] = v[i+1]; v[i+1] = t;
          nsw++; sw = 1;
        end else if (v[i] == v[i+1]) begin
          eq = 1;
        end
      end
      if (!sw) break;
    end
    for (int k = 0; k < 4; k++) sorted[k*W +: W] = v[k];
  endfunction

  task automatic do_sort(input logic [4*W-1:0] d, input bit spam, input string name);
    logic [4*W-1:0] exp_dout, prev;
    int exp_sw, exp_cmp, lat;
    bit exp_eq;
    model(d, exp_dout, exp_sw, exp_eq, exp_cmp);
    prev = dout;
    @(negedge clk); din = d; start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (done) begin lat = c; break; end
      checks++;
      if (dout !== prev || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s wait c%0d: busy=%b dout=%h, required busy=1 dout=%h",
                 name, c, busy, dout, prev);
      end
      @(negedge clk); start = spam; din = 16'($urandom);
      @(posedge clk);
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL %s timeout: no done within 10 cycles", name);
    end else begin
      if (lat !== exp_cmp + 1 || dout !== exp_dout || 32'(swaps) !== exp_sw ||
          eq_seen !== exp_eq || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s result: lat=%0d dout=%h swaps=%0d eq=%b busy=%b, required lat=%0d dout=%h swaps=%0d eq=%b busy=1",
                 name, lat, dout, swaps, eq_seen, busy, exp_cmp + 1, exp_dout, exp_sw, exp_eq);
      end
    end
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dout !== exp_dout) begin
        errors++;
        $display("FAIL %s after c%0d: done=%b busy=%b dout=%h, required 0 0 %h",
                 name, c, done, busy, dout, exp_dout);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== '0 || swaps !== '0 || eq_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dout=%h swaps=%0d eq=%b, required all 0",
               busy, done, dout, swaps, eq_seen);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    do_sort(16'h1234, 1'b0, "reversed");
    do_sort(16'h4321, 1'b0, "sorted");
    do_sort(16'h5555, 1'b0, "all_equal");
    do_sort(16'h0F0F, 1'b0, "f0f0");
    do_sort(16'h2113, 1'b0, "mixed");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) do_sort(16'($urandom), 1'b0, "random");
  endtask

  task automatic test_back_to_back();
    do_sort(16'h1234, 1'b1, "spam_rev");
    for (int n = 0; n < 5; n++) do_sort(16'($urandom), 1'b1, "spam_rand");
  endtask

  task automatic test_mid_reset();
    @(negedge clk); din = 16'h1234; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; din = 16'($urandom);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== '0 || swaps !== '0 || eq_seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b dout=%h swaps=%0d eq=%b, required all 0",
               busy, done, dout, swaps, eq_seen);
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset idle c%0d: done=%b busy=%b, required 0 0", c, done, busy);
      end
    end
    do_sort(16'h0F0F, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
